// File: rtl/bus_ram_model.sv
// Word-addressed RAM slave for the mips_cpu_bus interface.
// Byte-lane writes, programmable waitrequest stall, sticky error flag, debug peek.
module bus_ram_model #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = "",
  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          write,
  input  logic          read,
  output logic          waitrequest,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic [31:0]   readdata,
  output logic          err,
  input  logic [AW-1:0] dbg_word_addr,
  output logic [31:0]   dbg_word_data
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  typedef enum logic {IDLE, STALL} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [0:DEPTH-1];

  logic          w_req;
  logic          w_both;
  logic          w_wait;
  logic          w_access;
  logic          w_abort;
  logic [31:0]   w_off;
  logic [31:0]   w_idx;
  logic          w_in_range;
  logic          w_wr_en;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  assign w_req      = read | write;
  assign w_both     = read & write;
  assign w_off      = address - BASE_ADDR;
  assign w_idx      = w_off >> 2;
  assign w_in_range = (address >= BASE_ADDR) && (w_idx < DEPTH32);

  always_comb begin
    w_next   = r_state;
    w_wait   = 1'b0;
    w_access = 1'b0;
    w_abort  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES > 0) begin
            w_wait = 1'b1;
            w_next = STALL;
          end else begin
            w_access = 1'b1;
          end
        end
      end
      STALL: begin
        if (!w_req) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (r_cnt != '0) begin
          w_wait = 1'b1;
        end else begin
          w_access = 1'b1;
          w_next   = IDLE;
        end
      end
    endcase
  end

  assign waitrequest = w_wait & ~reset;
  assign w_wr_en     = w_access & write & ~read & w_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == STALL && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_abort || (w_access && (w_both || !w_in_range))) begin
        r_err <= 1'b1;
      end
      if (w_access && read && !write) begin
        r_rdata <= w_in_range ? r_mem[w_idx[AW-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          r_mem[w_idx[AW-1:0]][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  assign readdata      = r_rdata;
  assign err           = r_err;
  assign dbg_word_data = (32'(dbg_word_addr) < DEPTH32) ?
                         r_mem[dbg_word_addr] : '0;

endmodule

// File: tb/tb_bus_ram_model.sv
// Scoreboard bench for bus_ram_model: directed corner cases, then random
// traffic against an array-based memory model.
module tb_bus_ram_model;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 16;
  localparam int          WAIT  = 2;
  localparam int          AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic [31:0]   address;
  logic          write;
  logic          read;
  logic          waitrequest;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;
  logic          err;
  logic [AW-1:0] dbg_word_addr;
  logic [31:0]   dbg_word_data;

  bus_ram_model #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .read(read), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .err(err),
    .dbg_word_addr(dbg_word_addr), .dbg_word_data(dbg_word_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem[DEPTH];
  logic        model_err;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read completions: expected data was queued when the read was issued.
  always @(posedge clk) begin
    if (!reset && read && !write && !waitrequest) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected none", readdata);
      end else begin
        check("rdata", readdata, exp_q.pop_front());
      end
    end
  end

  function automatic void model_apply(logic rd, logic wr, logic [31:0] a,
                                      logic [31:0] d, logic [3:0] be);
    longint word;
    bit     in;
    word = (longint'(a) - longint'(BASE)) / 4;
    in   = (a >= BASE) && (word < DEPTH);
    if (rd && wr) begin
      model_err = 1'b1;
    end else if (!in) begin
      model_err = 1'b1;
      if (rd) exp_q.push_back(32'h0);
    end else if (rd) begin
      exp_q.push_back(model_mem[int'(word)]);
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[int'(word)][8*i +: 8] = d[8*i +: 8];
    end
  endfunction

  task automatic xfer(logic rd, logic wr, logic [31:0] a,
                      logic [31:0] d, logic [3:0] be);
    int n;
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    model_apply(rd, wr, a, d, be);
    n = 0;
    #1;
    while (waitrequest && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'(WAIT));
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    #1;
    check("err", 32'(err), 32'(model_err));
  endtask

  task automatic peek(string name, int w, logic [31:0] exp);
    dbg_word_addr = AW'(w);
    #1;
    check(name, dbg_word_data, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("wait_in_reset", 32'(waitrequest), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_err = 1'b0;
    #1;
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", readdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0; dbg_word_addr = '0;
    model_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait", 32'(waitrequest), 32'h0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) peek("init_zero", i, 32'h0);

    // Byte-lane writes
    xfer(1'b0, 1'b1, BASE + 32'h14, 32'h11223344, 4'b1111);
    xfer(1'b0, 1'b1, BASE + 32'h14, 32'hAABBCCDD, 4'b0101);
    peek("be_0101", 5, 32'h11BB33DD);
    xfer(1'b0, 1'b1, BASE + 32'h14, 32'hFFFFFFFF, 4'b0000);
    peek("be_0000", 5, 32'h11BB33DD);
    xfer(1'b0, 1'b1, BASE + 32'h4, 32'h8D09002C, 4'b1111);
    xfer(1'b0, 1'b1, BASE, 32'hCAFEF00D, 4'b1111);
    xfer(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'b0000);
    xfer(1'b1, 1'b0, BASE + 32'h16, 32'h0, 4'b0000);

    // Reset during the second stall cycle aborts the read
    @(negedge clk);
    read = 1'b1; address = BASE;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("wait_rst_stall", 32'(waitrequest), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0; read = 1'b0;
    #1;
    check("rst_stall_rdata", readdata, 32'h0);
    check("rst_stall_err", 32'(err), 32'h0);
    peek("rst_keeps_mem", 0, 32'hCAFEF00D);

    // Protocol / range errors
    xfer(1'b1, 1'b1, BASE + 32'h14, 32'h0, 4'b1111);
    peek("both_no_write", 5, 32'h11BB33DD);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
    xfer(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'b0000);
    xfer(1'b0, 1'b1, BASE - 32'h4, 32'h12345678, 4'b1111);

    // Dropping the request mid-stall
    do_reset();
    @(negedge clk);
    read = 1'b1; address = BASE + 32'h8;
    #1;
    check("abort_wait_hi", 32'(waitrequest), 32'h1);
    @(negedge clk);
    read = 1'b0;
    model_err = 1'b1;
    #1;
    check("abort_wait_lo", 32'(waitrequest), 32'h0);
    @(posedge clk);
    #1;
    check("abort_err", 32'(err), 32'h1);
    xfer(1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'b0000);

    // Random traffic
    do_reset();
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8)
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1))
                 + 32'($urandom_range(0, 3));
      else if (r == 8)
        a = BASE - 32'(4 * $urandom_range(1, 100));
      else
        a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 50));
      if ($urandom_range(0, 1) == 0)
        xfer(1'b1, 1'b0, a, 32'h0, 4'b0000);
      else
        xfer(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < DEPTH; i++) peek("final_mem", i, model_mem[i]);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
